// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue register stage feeding the 64-bit and 32-bit ALUs.
// Decodes RV64I OP / OP_32 / OP_IMM / OP_IMM_32 into a registered ALU bundle
// behind a valid/ready handshake.
// Optional feature: define ALU_ISSUE_SKID_EN to add a skid register so that
// in_ready becomes a registered signal with no combinational path from out_ready.
module alu_issue_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_function,
    output logic [XLEN-1:0] out_operand_a,
    output logic [XLEN-1:0] out_operand_b,
    output logic            out_word,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef struct packed {
        logic [3:0]      func;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            word;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_reg;
    logic       is_imm;
    logic       is_word;
    logic       is_shift;
    logic       illegal;
    bundle_t    dec;
    bundle_t    out_q;
    logic       accept;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    // Decode the incoming instruction into an ALU bundle; illegal encodings get a zero function and operand_b
    always_comb begin
        is_reg   = (opcode == OPC_OP) || (opcode == OPC_OP_32);
        is_imm   = (opcode == OPC_OP_IMM) || (opcode == OPC_OP_IMM_32);
        is_word  = (opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32);
        is_shift = is_imm && ((funct3 == 3'b001) || (funct3 == 3'b101));

        illegal = 1'b0;
        if (!is_reg && !is_imm)
            illegal = 1'b1;
        if (is_reg && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
            illegal = 1'b1;
        if (is_reg && (funct7 == 7'b0100000) && (funct3 != 3'b000) && (funct3 != 3'b101))
            illegal = 1'b1;
        if (is_word && (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b101))
            illegal = 1'b1;
        if (is_shift && !is_word) begin
            if ((in_inst[31:26] != 6'b000000) && (in_inst[31:26] != 6'b010000))
                illegal = 1'b1;
            if ((in_inst[31:26] == 6'b010000) && (funct3 == 3'b001))
                illegal = 1'b1;
        end
        if (is_shift && is_word) begin
            if ((funct7 != 7'b0000000) && (funct7 != 7'b0100000))
                illegal = 1'b1;
            if ((funct7 == 7'b0100000) && (funct3 == 3'b001))
                illegal = 1'b1;
        end

        dec         = '0;
        dec.a       = in_rs1_data;
        dec.rd      = in_inst[11:7];
        dec.word    = is_word;
        dec.illegal = illegal;
        if (!illegal) begin
            dec.func = {(is_reg || (funct3 == 3'b101)) ? in_inst[30] : 1'b0, funct3};
            if (is_reg)
                dec.b = in_rs2_data;
            else if (is_shift && is_word)
                dec.b = {{(XLEN-5){1'b0}}, in_inst[24:20]};
            else if (is_shift)
                dec.b = {{(XLEN-6){1'b0}}, in_inst[25:20]};
            else
                dec.b = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        end
    end

`ifdef ALU_ISSUE_SKID_EN
    bundle_t skid_q;
    logic    skid_valid;

    assign in_ready = !skid_valid || flush;
    assign accept   = in_valid && in_ready && !flush;

    // Output plus skid register pair: a stalled output parks one extra entry in the skid, drained in order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_q      <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid || out_ready || flush;
    assign accept   = in_valid && in_ready && !flush;

    // Single output register: load on accept, drop valid once consumed, clear valid on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_q     <= dec;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign out_alu_function = out_q.func;
    assign out_operand_a    = out_q.a;
    assign out_operand_b    = out_q.b;
    assign out_word         = out_q.word;
    assign out_rd           = out_q.rd;
    assign out_illegal      = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
// Works with or without ALU_ISSUE_SKID_EN defined.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_function;
    logic [63:0] out_operand_a;
    logic [63:0] out_operand_b;
    logic        out_word;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [3:0]  func;
        logic [63:0] b;
        logic        word;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    alu_issue_stage #(.XLEN(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_inst          (in_inst),
        .in_rs1_data      (in_rs1_data),
        .in_rs2_data      (in_rs2_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_alu_function (out_alu_function),
        .out_operand_a    (out_operand_a),
        .out_operand_b    (out_operand_b),
        .out_word         (out_word),
        .out_rd           (out_rd),
        .out_illegal      (out_illegal)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] add_inst(input logic [4:0] rd);
        return 32'h0020_8033 | {20'd0, rd, 7'd0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = 32'd0; in_rs1_data = 64'd0; in_rs2_data = 64'd0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_alu_function !== 4'd0 || out_operand_a !== 64'd0 ||
            out_operand_b !== 64'd0 || out_word !== 1'b0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b func=%h a=%h b=%h word=%b rd=%0d ill=%b, want all zero",
                     out_valid, out_alu_function, out_operand_a, out_operand_b, out_word, out_rd, out_illegal);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        vec_t v[13];
        v[0]  = '{32'h0020_81B3, 64'd5, 64'd7, 4'h0, 64'd7, 1'b0, 5'd3, 1'b0};
        v[1]  = '{32'h4073_02BB, 64'd100, 64'd30, 4'h8, 64'd30, 1'b1, 5'd5, 1'b0};
        v[2]  = '{32'h43F1_5093, 64'h8000_0000_0000_0000, 64'h1234, 4'hD, 64'd63, 1'b0, 5'd1, 1'b0};
        v[3]  = '{32'hFFF0_0093, 64'd0, 64'h1234, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1, 1'b0};
        v[4]  = '{32'h0200_909B, 64'd9, 64'h1234, 4'h0, 64'd0, 1'b1, 5'd1, 1'b1};
        v[5]  = '{32'h0000_007F, 64'd11, 64'd22, 4'h0, 64'd0, 1'b0, 5'd0, 1'b1};
        v[6]  = '{32'h4051_521B, 64'd3, 64'h1234, 4'hD, 64'd5, 1'b1, 5'd4, 1'b0};
        v[7]  = '{32'h0020_A333, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h2, 64'd1, 1'b0, 5'd6, 1'b0};
        v[8]  = '{32'h0231_00B3, 64'd6, 64'd7, 4'h0, 64'd0, 1'b0, 5'd1, 1'b1};
        v[9]  = '{32'hFF00_E393, 64'd8, 64'h1234, 4'h6, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5'd7, 1'b0};
        v[10] = '{32'h4020_A333, 64'd1, 64'd2, 4'h0, 64'd0, 1'b0, 5'd6, 1'b1};
        v[11] = '{32'hFFF1_009B, 64'd1, 64'h1234, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd1, 1'b0};
        v[12] = '{32'h0201_5093, 64'd1, 64'h1234, 4'h5, 64'd32, 1'b0, 5'd1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_inst = v[i].inst; in_rs1_data = v[i].rs1; in_rs2_data = v[i].rs2;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_illegal !== v[i].ill) begin
                failures++;
                $display("[TB] FAIL decode[%0d]_valid_illegal: got valid=%b ill=%b want valid=1 ill=%b",
                         i, out_valid, out_illegal, v[i].ill);
            end
            checks++;
            if (out_alu_function !== v[i].func || out_operand_b !== v[i].b) begin
                failures++;
                $display("[TB] FAIL decode[%0d]_func_b: got func=%h b=%h want func=%h b=%h",
                         i, out_alu_function, out_operand_b, v[i].func, v[i].b);
            end
            checks++;
            if (out_operand_a !== v[i].rs1 || out_word !== v[i].word || out_rd !== v[i].rd) begin
                failures++;
                $display("[TB] FAIL decode[%0d]_a_word_rd: got a=%h word=%b rd=%0d want a=%h word=%b rd=%0d",
                         i, out_operand_a, out_word, out_rd, v[i].rs1, v[i].word, v[i].rd);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = add_inst(5'(i + 10)); in_rs1_data = 64'(100 + i); in_rs2_data = 64'(200 + i);
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b[%0d]_in_ready: got %b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_rd !== 5'(i + 10) || out_operand_a !== 64'(100 + i) ||
                out_operand_b !== 64'(200 + i)) begin
                failures++;
                $display("[TB] FAIL b2b[%0d]_bundle: got valid=%b rd=%0d a=%0d b=%0d want valid=1 rd=%0d a=%0d b=%0d",
                         i, out_valid, out_rd, out_operand_a, out_operand_b, i + 10, 100 + i, 200 + i);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          recv = 0;
        int          stall_acc = 0;
        logic        prev_hold = 1'b0;
        logic [4:0]  prev_rd = '0;
        logic [63:0] prev_a = '0;
        logic [63:0] prev_b = '0;
        int          want_stall_acc;
        logic        want_ready_at_release;
`ifdef ALU_ISSUE_SKID_EN
        want_stall_acc = 1;
        want_ready_at_release = 1'b0;
`else
        want_stall_acc = 0;
        want_ready_at_release = 1'b1;
`endif
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            in_valid    = (sent < 4);
            in_inst     = add_inst(5'(sent + 1));
            in_rs1_data = 64'(10 + sent);
            in_rs2_data = 64'(20 + sent);
            out_ready   = !(cyc >= 2 && cyc <= 4);
            #1;
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_rd !== prev_rd || out_operand_a !== prev_a || out_operand_b !== prev_b) begin
                    failures++;
                    $display("[TB] FAIL bp_hold_cyc%0d: got valid=%b rd=%0d a=%0d b=%0d want valid=1 rd=%0d a=%0d b=%0d",
                             cyc, out_valid, out_rd, out_operand_a, out_operand_b, prev_rd, prev_a, prev_b);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (in_ready !== want_ready_at_release) begin
                    failures++;
                    $display("[TB] FAIL bp_in_ready_release: got %b want %b", in_ready, want_ready_at_release);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_rd !== 5'(recv + 1) || out_operand_a !== 64'(10 + recv) || out_operand_b !== 64'(20 + recv)) begin
                    failures++;
                    $display("[TB] FAIL bp_order[%0d]: got rd=%0d a=%0d b=%0d want rd=%0d a=%0d b=%0d",
                             recv, out_rd, out_operand_a, out_operand_b, recv + 1, 10 + recv, 20 + recv);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                if (out_valid && !out_ready) stall_acc++;
                sent++;
            end
            prev_hold = out_valid && !out_ready;
            prev_rd   = out_rd;
            prev_a    = out_operand_a;
            prev_b    = out_operand_b;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 4) begin
            failures++;
            $display("[TB] FAIL bp_received: got %0d want 4 within cycle budget", recv);
        end
        checks++;
        if (stall_acc != want_stall_acc) begin
            failures++;
            $display("[TB] FAIL bp_stall_accepts: got %0d want %0d", stall_acc, want_stall_acc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_inst = add_inst(5'd21); in_rs1_data = 64'd1; in_rs2_data = 64'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_inst = add_inst(5'd22);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd21) begin
            failures++;
            $display("[TB] FAIL flush_setup: got valid=%b rd=%0d want valid=1 rd=21", out_valid, out_rd);
        end
        in_inst = add_inst(5'd23);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_out_valid: got %b want 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_dropped: got out_valid=%b rd=%0d want out_valid=0", out_valid, out_rd);
        end
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        in_inst = 32'h4073_02BB; in_rs1_data = 64'd77; in_rs2_data = 64'd88; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_alu_function !== 4'd0 || out_operand_a !== 64'd0 ||
            out_operand_b !== 64'd0 || out_word !== 1'b0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got valid=%b func=%h a=%h b=%h word=%b rd=%0d ill=%b, want all zero",
                     out_valid, out_alu_function, out_operand_a, out_operand_b, out_word, out_rd, out_illegal);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    // Run every scenario in order, then report the totals
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
